sx_reg_mux: RTL and testbench

SX_REG_MUX -- requirements
Module: sx_reg_mux

---
 rtl/sx_reg_mux.sv | 122 ++++++++++++
 tb/tb_sx_reg_mux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sx_reg_mux.sv
// sx_reg_mux -- 4:1 word select followed by a DEPTH-stage elastic register pipe.
//
// A word is chosen from d0..d3 by two select terms:
//   sel_lo = a0 & a1,  sel_hi = b0 | b1,  word = d[{sel_hi,sel_lo}].
// The chosen word enters stage 0 on accept (in_valid & in_ready). It then moves
// toward out (stage DEPTH-1) with valid/ready handshaking. Empty stages are
// refilled as soon as possible, so bubbles do not persist.
//
// Ports
//   clk                 rising-edge clock
//   CLR                 synchronous active-high clear of every stage (data and valid)
//   d0..d3 [WIDTH]      candidate words
//   a0,a1,b0,b1         select terms, sampled together with the data
//   in_valid/in_ready   upstream handshake
//   out [WIDTH]         registered selected word
//   out_valid/out_ready downstream handshake
//   xfer_cnt [16]       wrapping count of delivered words
//                       (present only when SX_REG_MUX_CNT_EN is defined)
//
// Optional feature macro: SX_REG_MUX_CNT_EN

module sx_reg_mux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             a0,
  input  logic             a1,
  input  logic             b0,
  input  logic             b1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SX_REG_MUX_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  logic                        w_sel_lo, w_sel_hi;
  logic [WIDTH-1:0]            w_word;
  logic [DEPTH-1:0]            r_vld;    // per-stage valid bits
  logic [DEPTH-1:0][WIDTH-1:0] r_data;   // per-stage data
  logic [DEPTH-1:0]            w_ld;     // stage k takes its source this cycle
  logic [DEPTH-1:0]            w_src_v;  // valid feeding stage k
  logic [DEPTH-1:0][WIDTH-1:0] w_src_d;  // data feeding stage k

  always_comb begin
    w_sel_lo = a0 & a1;
    w_sel_hi = b0 | b1;
    case ({w_sel_hi, w_sel_lo})
      2'b11:   w_word = d3;
      2'b10:   w_word = d2;
      2'b01:   w_word = d1;
      default: w_word = d0;
    endcase
  end

  // Load enables are resolved from the output backward. A stage loads when it
  // is empty or when its contents are leaving. The ready signal therefore
  // ripples through every stage in one cycle, which gives full throughput and
  // lets bubbles collapse immediately.
  always_comb begin
    logic w_go;
    w_ld = '0;
    w_go = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_ld[k] = ~r_vld[k] | w_go;
      w_go    = w_ld[k];
    end
  end

  always_comb begin
    w_src_v    = '0;
    w_src_d    = '0;
    w_src_v[0] = in_valid;
    w_src_d[0] = w_word;
    for (int k = 1; k < DEPTH; k++) begin
      w_src_v[k] = r_vld[k-1];
      w_src_d[k] = r_data[k-1];
    end
  end

  assign in_ready  = w_ld[0];
  assign out       = r_data[DEPTH-1];
  assign out_valid = r_vld[DEPTH-1];

  // Data is updated only when a real word arrives. A bubble clears the valid
  // bit but keeps the old data, which avoids needless toggling.
  always_ff @(posedge clk) begin
    if (CLR) begin
      r_vld  <= '0;
      r_data <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_ld[k]) begin
          r_vld[k] <= w_src_v[k];
          if (w_src_v[k]) r_data[k] <= w_src_d[k];
        end
      end
    end
  end

`ifdef SX_REG_MUX_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (CLR)                        r_cnt <= '0;
    else if (out_valid && out_ready) r_cnt <= r_cnt + 16'd1;
  end

  assign xfer_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_sx_reg_mux.sv
module tb_sx_reg_mux;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic CLR;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic a0, a1, b0, b1;
  logic in_valid, in_ready;
  logic [WIDTH-1:0] out;
  logic out_valid, out_ready;
`ifdef SX_REG_MUX_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  sx_reg_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .CLR(CLR),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SX_REG_MUX_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] w;
    int               cyc;
    logic             lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, n_acc = 0;
  logic [15:0] tb_cnt = '0;
  logic [WIDTH-1:0] exp_w;
  logic lat_chk;

  // Expected words for the 16 select combinations {a0,a1,b0,b1}.
  // The data inputs are 11/22/33/44.
  logic [7:0] exp_tab [16] = '{8'h11, 8'h33, 8'h33, 8'h33, 8'h11, 8'h33, 8'h33, 8'h33,
                               8'h11, 8'h33, 8'h33, 8'h33, 8'h22, 8'h44, 8'h44, 8'h44};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(logic [3:0] s);
    logic lo, hi;
    lo = s[3] & s[2];
    hi = s[1] | s[0];
    if (hi && lo)  return d3;
    else if (hi)   return d2;
    else if (lo)   return d1;
    else           return d0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard push. It samples just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (CLR) sb.delete();
    else if (in_valid && in_ready) begin
      sb.push_back('{w: exp_w, cyc: cyc, lat: lat_chk});
      n_acc++;
    end
  end

  // Monitor. It pops and compares on every delivery.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (CLR) tb_cnt = '0;
    else if (out_valid && out_ready) begin
      tb_cnt = tb_cnt + 16'd1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_delivery: got %0h with nothing expected", out);
      end else begin
        e = sb.pop_front();
        chk("out_word", 32'(out), 32'(e.w));
        if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(DEPTH));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(logic v, logic [3:0] s, logic [WIDTH-1:0] w, logic l);
    in_valid = v;
    {a0, a1, b0, b1} = s;
    exp_w = w;
    lat_chk = l;
  endtask

  initial begin
    int n0;
    CLR = 1'b1; out_ready = 1'b1;
    d0 = 8'h11; d1 = 8'h22; d2 = 8'h33; d3 = 8'h44;
    drive(1'b1, 4'hF, 8'h44, 1'b0);
    // Hold reset for two cycles while an offer is present.
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
`ifdef SX_REG_MUX_CNT_EN
    chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
`endif
    CLR = 1'b0;
    drive(1'b0, 4'h0, 8'h11, 1'b0);
    tick();
    chk("in_ready_after_clr", 32'(in_ready), 1);

    // Stream all 16 select combinations back to back with a fixed latency.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), exp_tab[i], 1'b1);
      tick();
    end
    drive(1'b0, 4'h0, 8'h11, 1'b0);
    repeat (4) tick();
    chk("sel_drained", 32'(sb.size()), 0);

    // Stall test: hold out_ready low for 5 offers.
    out_ready = 1'b0;
    n0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      d0 = 8'hA0 + 8'(i);
      drive(1'b1, 4'h0, d0, 1'b0);
      if (i >= DEPTH) begin
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_out_stable", 32'(out), 32'h000000A0);
      end
      tick();
    end
    chk("stall_accepts", 32'(n_acc - n0), 32'(DEPTH));
    drive(1'b0, 4'h0, 8'h00, 1'b0);
    out_ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      chk("release_b2b", 32'(out_valid), 1);
      tick();
    end
    tick();
    chk("stall_drained", 32'(sb.size()), 0);

    // Put two words in flight, then clear the block while accept and deliver are both offered.
    out_ready = 1'b0;
    d0 = 8'hB0; drive(1'b1, 4'h0, d0, 1'b0); tick();
    d0 = 8'hB1; drive(1'b1, 4'h0, d0, 1'b0); tick();
    d0 = 8'hB2; drive(1'b1, 4'h0, d0, 1'b0);
    out_ready = 1'b1; CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 0);
    chk("clr_out", 32'(out), 0);
    d0 = 8'hC5; drive(1'b1, 4'h0, d0, 1'b0); tick();
    drive(1'b0, 4'h0, d0, 1'b0);
    repeat (4) tick();
    chk("clr_drained", 32'(sb.size()), 0);

    // Random handshake traffic.
    for (int i = 0; i < 10000; i++) begin
      logic [3:0] s;
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
      s = 4'($urandom);
      out_ready = 1'($urandom);
      {a0, a1, b0, b1} = s;
      drive(1'($urandom), s, model(s), 1'b0);
      tick();
    end
    drive(1'b0, 4'h0, 8'h00, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    chk("random_drained", 32'(sb.size()), 0);

`ifdef SX_REG_MUX_CNT_EN
    chk("cnt_matches", 32'(xfer_cnt), 32'(tb_cnt));
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("cnt_clr", 32'(xfer_cnt), 0);
    d0 = 8'h5A;
    drive(1'b1, 4'h0, d0, 1'b0);
    repeat (65537) tick();
    drive(1'b0, 4'h0, d0, 1'b0);
    repeat (DEPTH + 2) tick();
    chk("cnt_wrap", 32'(xfer_cnt), 32'h0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
